// File: rtl/sdram_burst_datapath.sv
// SDRAM DQ/DQM burst data path: owns bus direction and byte masks
// for burst writes and CAS-aligned burst read capture.
module sdram_burst_datapath #(
  parameter int DATA_W    = 16,
  parameter int MASK_W    = DATA_W / 8,
  parameter int BURST_LEN = 4,
  parameter int CAS_LAT   = 2
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  inout  wire  [DATA_W-1:0] sdram_dq,
  output logic [MASK_W-1:0] sdram_dqm,
  input  logic              wr_start,
  input  logic              rd_start,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  output logic              wr_data_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              proto_err
);

  localparam int RD_END = CAS_LAT + BURST_LEN;
  localparam int CNT_W  = $clog2(RD_END + 2);

  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] RD_FIRST = CNT_W'(CAS_LAT);
  localparam logic [CNT_W-1:0] RD_LASTC = CNT_W'(RD_END - 1);
  localparam logic [CNT_W-1:0] RD_DONE  = CNT_W'(RD_END);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [DATA_W-1:0]   dq_out_q;
  logic                dq_oe_q;
  logic [MASK_W-1:0]   dqm_q;
  logic                req_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                rd_last_q;
  logic                busy_q;
  logic                perr_q;
  logic                perr_d;
  logic                rd_go;
  logic                in_win;

  assign cnt_nxt = cnt_q + CNT_W'(1);
  assign in_win  = (cnt_q >= RD_FIRST) && (cnt_q <= RD_LASTC);

  // DQM must already be low in the READ command cycle itself
  assign rd_go  = (state_q == S_IDLE) && rd_start && !wr_start;
  assign perr_d = busy_q ? (wr_start | rd_start)
                         : (wr_start & rd_start);

  assign sdram_dq    = dq_oe_q ? dq_out_q : 'z;
  assign sdram_dqm   = rd_go ? '0 : dqm_q;
  assign wr_data_req = req_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_last     = rd_last_q;
  assign busy        = busy_q;
  assign proto_err   = perr_q;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      dqm_q      <= '1;
      req_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      perr_q <= perr_d;
      unique case (state_q)
        S_IDLE: begin
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
          if (wr_start) begin
            state_q  <= S_WRITE;
            cnt_q    <= '0;
            dq_out_q <= wr_data;
            dqm_q    <= wr_mask;
            dq_oe_q  <= 1'b1;
            busy_q   <= 1'b1;
            req_q    <= (BURST_LEN > 1);
          end else if (rd_start) begin
            state_q <= S_READ;
            cnt_q   <= CNT_W'(1);
            dqm_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (cnt_q == WR_LAST) begin
            state_q <= S_IDLE;
            dq_oe_q <= 1'b0;
            dqm_q   <= '1;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
          end else begin
            cnt_q    <= cnt_nxt;
            dq_out_q <= wr_data;
            dqm_q    <= wr_mask;
            req_q    <= (cnt_nxt < WR_LAST);
          end
        end
        S_READ: begin
          cnt_q      <= cnt_nxt;
          rd_valid_q <= in_win;
          rd_last_q  <= (cnt_q == RD_LASTC);
          if (in_win) begin
            rd_data_q <= sdram_dq;
          end
          dqm_q <= (cnt_nxt <= RD_LASTC) ? '0 : '1;
          // busy spans the whole CAS window so a write can follow at once
          if (cnt_q == RD_DONE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_datapath.sv
// Bench for sdram_burst_datapath: two configurations checked against
// a per-cycle expectation schedule built from the burst timing rules.
module tb_sdram_burst_datapath;

  logic clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  int cyc = 0;
  always @(posedge clk_100m) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DW = (g == 0) ? 16 : 32;
    localparam int MW = DW / 8;
    localparam int BL = (g == 0) ? 4 : 8;
    localparam int CL = (g == 0) ? 2 : 3;
    localparam int RN = 32;

    logic          rst_n;
    wire  [DW-1:0] dq;
    logic [MW-1:0] dqm;
    logic          wr_start;
    logic          rd_start;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_mask;
    logic          wr_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          busy;
    logic          perr;
    logic          done_g = 1'b0;

    logic          drv_en = 1'b0;
    logic [DW-1:0] drv_val = '0;
    assign dq = drv_en ? drv_val : 'z;

    sdram_burst_datapath #(
      .DATA_W(DW),
      .BURST_LEN(BL),
      .CAS_LAT(CL)
    ) dut (
      .clk_100m(clk_100m),
      .rst_n(rst_n),
      .sdram_dq(dq),
      .sdram_dqm(dqm),
      .wr_start(wr_start),
      .rd_start(rd_start),
      .wr_data(wr_data),
      .wr_mask(wr_mask),
      .wr_data_req(wr_req),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .rd_last(rd_last),
      .busy(busy),
      .proto_err(perr)
    );

    // expectation ring indexed by absolute cycle number
    logic          e_oe[RN];
    logic          e_req[RN];
    logic          e_busy[RN];
    logic          e_val[RN];
    logic          e_last[RN];
    logic          e_perr[RN];
    logic          e_drv[RN];
    logic [DW-1:0] e_dq[RN];
    logic [DW-1:0] e_rd[RN];
    logic [DW-1:0] d_val[RN];
    logic [MW-1:0] e_dqm[RN];

    int            busy_end = -1;
    int            wr_t0 = 0;
    int            wr_next = BL;
    logic [DW-1:0] last_rd = '0;

    task automatic clr(input int c);
      int i;
      i = c % RN;
      e_oe[i]   = 1'b0;
      e_req[i]  = 1'b0;
      e_busy[i] = 1'b0;
      e_val[i]  = 1'b0;
      e_last[i] = 1'b0;
      e_perr[i] = 1'b0;
      e_drv[i]  = 1'b0;
      e_dq[i]   = '0;
      e_rd[i]   = '0;
      d_val[i]  = '0;
      e_dqm[i]  = '1;
    endtask

    task automatic step(input int n);
      repeat (n) begin
        @(posedge clk_100m);
        #1;
      end
    endtask

    initial begin
      for (int i = 0; i < RN; i++) clr(i);
    end

    always @(posedge clk_100m) begin
      #1;
      drv_en  = e_drv[cyc % RN];
      drv_val = d_val[cyc % RN];
    end

    always @(negedge clk_100m) begin
      int n;
      int i;
      logic [DW-1:0] v;
      n = cyc;
      if (!rst_n) begin
        for (int k = 0; k < RN; k++) clr(k);
        busy_end = -1;
        wr_next  = BL;
        last_rd  = '0;
      end else begin
        if (wr_next < BL && n == wr_t0 + wr_next) begin
          e_dq[(n + 1) % RN]  = wr_data;
          e_dqm[(n + 1) % RN] = wr_mask;
          wr_next++;
        end
        if (n <= busy_end) begin
          if (wr_start || rd_start) e_perr[(n + 1) % RN] = 1'b1;
        end else if (wr_start) begin
          if (rd_start) e_perr[(n + 1) % RN] = 1'b1;
          for (int k = 1; k <= BL; k++) begin
            e_busy[(n + k) % RN] = 1'b1;
            e_oe[(n + k) % RN]   = 1'b1;
            if (k < BL) e_req[(n + k) % RN] = 1'b1;
          end
          e_dq[(n + 1) % RN]  = wr_data;
          e_dqm[(n + 1) % RN] = wr_mask;
          wr_t0    = n;
          wr_next  = 1;
          busy_end = n + BL;
        end else if (rd_start) begin
          for (int k = 0; k < CL + BL; k++) e_dqm[(n + k) % RN] = '0;
          for (int k = 1; k <= CL + BL; k++) e_busy[(n + k) % RN] = 1'b1;
          for (int b = 0; b < BL; b++) begin
            v = DW'({$urandom(), $urandom()});
            e_drv[(n + CL + b) % RN]     = 1'b1;
            d_val[(n + CL + b) % RN]     = v;
            e_val[(n + CL + b + 1) % RN] = 1'b1;
            e_rd[(n + CL + b + 1) % RN]  = v;
            e_last[(n + CL + b + 1) % RN] = (b == BL - 1);
          end
          busy_end = n + CL + BL;
        end
      end
      i = n % RN;
      if (e_val[i]) last_rd = e_rd[i];
      chk($sformatf("g%0d c%0d oe", g, n), 64'(dut.dq_oe_q), 64'(e_oe[i]));
      if (e_oe[i]) chk($sformatf("g%0d c%0d dq", g, n), 64'(dq), 64'(e_dq[i]));
      chk($sformatf("g%0d c%0d dqm", g, n), 64'(dqm), 64'(e_dqm[i]));
      chk($sformatf("g%0d c%0d req", g, n), 64'(wr_req), 64'(e_req[i]));
      chk($sformatf("g%0d c%0d busy", g, n), 64'(busy), 64'(e_busy[i]));
      chk($sformatf("g%0d c%0d rvalid", g, n), 64'(rd_valid), 64'(e_val[i]));
      chk($sformatf("g%0d c%0d rlast", g, n), 64'(rd_last), 64'(e_last[i]));
      chk($sformatf("g%0d c%0d rdata", g, n), 64'(rd_data), 64'(last_rd));
      chk($sformatf("g%0d c%0d perr", g, n), 64'(perr), 64'(e_perr[i]));
      clr(n);
    end

    initial begin
      rst_n    = 1'b0;
      wr_start = 1'b0;
      rd_start = 1'b0;
      wr_data  = '0;
      wr_mask  = '0;
      step(3);
      rst_n = 1'b1;
      // directed write: A001.. with the listed masks
      for (int k = 0; k < BL; k++) begin
        wr_start = (k == 0);
        wr_data  = DW'(32'hA001 + k);
        wr_mask  = (g == 0) ? MW'((k == 1) ? 1 : (k == 2) ? 2 : 0)
                            : MW'(4'hA);
        step(1);
      end
      wr_start = 1'b0;
      step(BL + 2);
      // read, then a write in the first non-busy cycle
      rd_start = 1'b1;
      step(1);
      rd_start = 1'b0;
      step(CL + BL);
      wr_start = 1'b1;
      step(1);
      wr_start = 1'b0;
      step(1);
      wr_start = 1'b1;
      step(1);
      wr_start = 1'b0;
      step(BL + 2);
      wr_start = 1'b1;
      rd_start = 1'b1;
      step(1);
      wr_start = 1'b0;
      rd_start = 1'b0;
      step(BL + 2);
      repeat (400) begin
        wr_start = ($urandom_range(0, 5) == 0);
        rd_start = ($urandom_range(0, 5) == 0);
        wr_data  = DW'({$urandom(), $urandom()});
        wr_mask  = MW'($urandom());
        step(1);
      end
      wr_start = 1'b0;
      rd_start = 1'b0;
      step(CL + BL + 2);
      // reset in T2 of a write
      wr_start = 1'b1;
      step(1);
      wr_start = 1'b0;
      step(1);
      #2;
      rst_n = 1'b0;
      #1;
      chk($sformatf("g%0d async oe", g), 64'(dut.dq_oe_q), 64'd0);
      chk($sformatf("g%0d async dqm", g), 64'(dqm), 64'((1 << MW) - 1));
      chk($sformatf("g%0d async busy", g), 64'(busy), 64'd0);
      @(posedge clk_100m);
      @(posedge clk_100m);
      #1;
      rst_n = 1'b1;
      step(10);
      repeat (30) begin
        wr_start = ($urandom_range(0, 3) == 0);
        rd_start = ($urandom_range(0, 3) == 0);
        wr_data  = DW'({$urandom(), $urandom()});
        wr_mask  = MW'($urandom());
        step(1);
      end
      wr_start = 1'b0;
      rd_start = 1'b0;
      step(CL + BL + 3);
      done_g = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk_100m);
      if (u[0].done_g && u[1].done_g) break;
    end
    chk("all_done", 64'(u[0].done_g & u[1].done_g), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
